// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode constants and pipeline controller state.
package core_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-status inputs and sequencing-control outputs of the hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [6:0]       i_ifid_opcode;
  logic [4:0]       i_ifid_rs1addr;
  logic [4:0]       i_ifid_rs2addr;
  logic [4:0]       i_idex_rdaddr;
  logic             i_idex_rdwren;
  logic             i_idex_memrd;
  logic [4:0]       i_exmem_rdaddr;
  logic             i_exmem_rdwren;
  logic             i_exmem_memrd;
  logic             i_br_taken;
  logic             i_dmem_busy;
  logic             o_pc_en;
  logic             o_pc_sel;
  logic             o_ifid_en;
  logic             o_ifid_flush;
  logic             o_idex_flush;
  logic             o_exmem_en;
  logic             o_memwb_en;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_ifid_opcode, i_ifid_rs1addr, i_ifid_rs2addr,
    output i_idex_rdaddr, i_idex_rdwren, i_idex_memrd,
    output i_exmem_rdaddr, i_exmem_rdwren, i_exmem_memrd,
    output i_br_taken, i_dmem_busy,
    input  o_pc_en, o_pc_sel, o_ifid_en, o_ifid_flush, o_idex_flush,
    input  o_exmem_en, o_memwb_en, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_ifid_opcode, i_ifid_rs1addr, i_ifid_rs2addr,
    input  i_idex_rdaddr, i_idex_rdwren, i_idex_memrd,
    input  i_exmem_rdaddr, i_exmem_rdwren, i_exmem_memrd,
    input  i_br_taken, i_dmem_busy,
    output o_pc_en, o_pc_sel, o_ifid_en, o_ifid_flush, o_idex_flush,
    output o_exmem_en, o_memwb_en, o_stall_cnt, o_flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational decode of the ID instruction and the number of stall cycles
// its source operands require given the EX and MEM destinations.
module hazard_detect
  import core_pkg::*;
#(
  parameter int BR_LD_EX_STALL = 2
) (
  input  logic [6:0] opcode,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_rd_wren,
  input  logic       ex_mem_rd,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_rd_wren,
  input  logic       mem_mem_rd,
  output logic       is_br,
  output logic       is_jal,
  output logic       is_jalr,
  output logic [1:0] need
);

  logic uses_rs1;
  logic uses_rs2;
  logic ex_hit;
  logic mem_hit;
  logic id_resolves;

  assign is_br       = (opcode == OP_BRANCH);
  assign is_jal      = (opcode == OP_JAL);
  assign is_jalr     = (opcode == OP_JALR);
  assign uses_rs1    = !is_jal;
  assign uses_rs2    = !is_jal && !is_jalr;
  assign id_resolves = is_br || is_jalr;

  assign ex_hit = ex_rd_wren && (ex_rd_addr != 5'd0) &&
                  ((uses_rs1 && (ex_rd_addr == rs1_addr)) ||
                   (uses_rs2 && (ex_rd_addr == rs2_addr)));

  assign mem_hit = mem_rd_wren && (mem_rd_addr != 5'd0) &&
                   ((uses_rs1 && (mem_rd_addr == rs1_addr)) ||
                    (uses_rs2 && (mem_rd_addr == rs2_addr)));

  // ID-resolved control flow must wait even for ALU results, since forwarding
  // only reaches EX in time.
  always_comb begin
    need = 2'd0;
    if (id_resolves && ex_hit)
      need = ex_mem_rd ? 2'(BR_LD_EX_STALL) : 2'd1;
    else if (id_resolves && mem_hit && mem_mem_rd)
      need = 2'd1;
    else if (!id_resolves && ex_hit && ex_mem_rd)
      need = 2'd1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall FSM, stall/flush/redirect control
// generation and stall/flush performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int BR_LD_EX_STALL = 2
) (
  input logic          i_clk,
  input logic          i_rst_n,
  hazard_ctrl_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic [1:0]       rem_q;
  logic [1:0]       rem_d;
  logic [1:0]       need;
  logic             is_br;
  logic             is_jal;
  logic             is_jalr;
  logic             stall_cyc;
  logic             redirect;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  hazard_detect #(
    .BR_LD_EX_STALL(BR_LD_EX_STALL)
  ) u_detect (
    .opcode      (bus.i_ifid_opcode),
    .rs1_addr    (bus.i_ifid_rs1addr),
    .rs2_addr    (bus.i_ifid_rs2addr),
    .ex_rd_addr  (bus.i_idex_rdaddr),
    .ex_rd_wren  (bus.i_idex_rdwren),
    .ex_mem_rd   (bus.i_idex_memrd),
    .mem_rd_addr (bus.i_exmem_rdaddr),
    .mem_rd_wren (bus.i_exmem_rdwren),
    .mem_mem_rd  (bus.i_exmem_memrd),
    .is_br       (is_br),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .need        (need)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // A busy data memory freezes the FSM exactly where it is.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!bus.i_dmem_busy) begin
      case (state_q)
        RUN: begin
          if (need != 2'd0) begin
            rem_d   = need - 2'd1;
            state_d = (need > 2'd1) ? STALL : RUN;
          end
        end
        STALL: begin
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1)
            state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    bus.o_pc_en      = 1'b0;
    bus.o_pc_sel     = 1'b0;
    bus.o_ifid_en    = 1'b0;
    bus.o_ifid_flush = 1'b0;
    bus.o_idex_flush = 1'b0;
    bus.o_exmem_en   = 1'b0;
    bus.o_memwb_en   = 1'b0;
    redirect         = 1'b0;
    stall_cyc        = (state_q == STALL) || (need != 2'd0);
    if (i_rst_n && !bus.i_dmem_busy) begin
      bus.o_exmem_en = 1'b1;
      bus.o_memwb_en = 1'b1;
      if (stall_cyc) begin
        bus.o_idex_flush = 1'b1;
      end else begin
        bus.o_pc_en      = 1'b1;
        bus.o_ifid_en    = 1'b1;
        redirect         = is_jal || is_jalr || (is_br && bus.i_br_taken);
        bus.o_pc_sel     = redirect;
        bus.o_ifid_flush = redirect;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!bus.o_pc_en)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level reference model of the sequencing rules.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int         BR_STALL = 2;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  typedef struct {
    logic        pc_en;
    logic        pc_sel;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_en;
    logic        memwb_en;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   total;
  int   bad;

  int          pend;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  hazard_ctrl_if #(.CNT_W(32)) bus ();

  hazard_ctrl #(
    .CNT_W          (32),
    .BR_LD_EX_STALL (BR_STALL)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit src_hit(input logic [4:0] rd, input logic wr,
                                 input logic [4:0] rs, input bit used);
    return used && wr && (rd != 5'd0) && (rd == rs);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response of that cycle.
  task automatic applyStimulus(input logic rst_v, input logic [6:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] ex_rd, input logic ex_wr, input logic ex_ld,
                               input logic [4:0] mem_rd, input logic mem_wr, input logic mem_ld,
                               input logic taken, input logic busy);
    exp_t e;
    bit   u1, u2, ctrl, ex_dep, mem_dep;
    int   need;
    @(posedge clk);
    #1;
    rst_n                 = rst_v;
    bus.i_ifid_opcode     = op;
    bus.i_ifid_rs1addr    = rs1;
    bus.i_ifid_rs2addr    = rs2;
    bus.i_idex_rdaddr     = ex_rd;
    bus.i_idex_rdwren     = ex_wr;
    bus.i_idex_memrd      = ex_ld;
    bus.i_exmem_rdaddr    = mem_rd;
    bus.i_exmem_rdwren    = mem_wr;
    bus.i_exmem_memrd     = mem_ld;
    bus.i_br_taken        = taken;
    bus.i_dmem_busy       = busy;

    u1      = (op != OP_JAL);
    u2      = (op != OP_JAL) && (op != OP_JALR);
    ctrl    = (op == OP_BRANCH) || (op == OP_JALR);
    ex_dep  = src_hit(ex_rd, ex_wr, rs1, u1) || src_hit(ex_rd, ex_wr, rs2, u2);
    mem_dep = src_hit(mem_rd, mem_wr, rs1, u1) || src_hit(mem_rd, mem_wr, rs2, u2);
    if (ctrl && ex_dep)                need = ex_ld ? BR_STALL : 1;
    else if (ctrl && mem_dep && mem_ld) need = 1;
    else if (ex_dep && ex_ld)           need = 1;
    else                                need = 0;

    e = '{pc_en: 1'b0, pc_sel: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
          idex_flush: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
          stall_cnt: m_stall, flush_cnt: m_flush};
    if (!rst_v) begin
      pend        = 0;
      m_stall     = 0;
      m_flush     = 0;
      e.stall_cnt = 0;
      e.flush_cnt = 0;
    end else if (busy) begin
      m_stall++;
    end else begin
      e.exmem_en = 1'b1;
      e.memwb_en = 1'b1;
      if (pend > 0 || need > 0) begin
        e.idex_flush = 1'b1;
        m_stall++;
        if (pend > 0) pend--;
        else          pend = need - 1;
      end else begin
        e.pc_en   = 1'b1;
        e.ifid_en = 1'b1;
        if (op == OP_JAL || op == OP_JALR || (op == OP_BRANCH && taken)) begin
          e.pc_sel     = 1'b1;
          e.ifid_flush = 1'b1;
          m_flush++;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pc_en",      32'(bus.o_pc_en),      32'(e.pc_en));
        checkOutput("pc_sel",     32'(bus.o_pc_sel),     32'(e.pc_sel));
        checkOutput("ifid_en",    32'(bus.o_ifid_en),    32'(e.ifid_en));
        checkOutput("ifid_flush", 32'(bus.o_ifid_flush), 32'(e.ifid_flush));
        checkOutput("idex_flush", 32'(bus.o_idex_flush), 32'(e.idex_flush));
        checkOutput("exmem_en",   32'(bus.o_exmem_en),   32'(e.exmem_en));
        checkOutput("memwb_en",   32'(bus.o_memwb_en),   32'(e.memwb_en));
        checkOutput("stall_cnt",  bus.o_stall_cnt,       e.stall_cnt);
        checkOutput("flush_cnt",  bus.o_flush_cnt,       e.flush_cnt);
      end
    end
  end

  initial begin
    logic [6:0] ops [5];
    logic [6:0] op;
    total   = 0;
    bad     = 0;
    pend    = 0;
    m_stall = 0;
    m_flush = 0;
    rst_n   = 1'b0;
    ops[0] = OP_BRANCH; ops[1] = OP_JALR; ops[2] = OP_JAL; ops[3] = OP_LOAD; ops[4] = OP_ALU;
    bus.i_ifid_opcode  = OP_ALU;
    bus.i_ifid_rs1addr = '0;
    bus.i_ifid_rs2addr = '0;
    bus.i_idex_rdaddr  = '0;
    bus.i_idex_rdwren  = 1'b0;
    bus.i_idex_memrd   = 1'b0;
    bus.i_exmem_rdaddr = '0;
    bus.i_exmem_rdwren = 1'b0;
    bus.i_exmem_memrd  = 1'b0;
    bus.i_br_taken     = 1'b0;
    bus.i_dmem_busy    = 1'b0;

    $display("[TB] reset and reset mid-stall");
    applyStimulus(1'b0, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, OP_BRANCH, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_BRANCH, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    $display("[TB] load in EX feeding ID branch");
    repeat (2) applyStimulus(1'b1, OP_BRANCH, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_BRANCH, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] ALU result feeding jalr");
    applyStimulus(1'b1, OP_JALR, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JALR, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);

    $display("[TB] hazard-free branch taken and not taken");
    applyStimulus(1'b1, OP_BRANCH, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_BRANCH, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] load-use and load to x0");
    applyStimulus(1'b1, OP_ALU, 5'd3, 5'd1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ALU, 5'd3, 5'd1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ALU, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] dmem busy inside a branch stall");
    applyStimulus(1'b1, OP_BRANCH, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, OP_BRANCH, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, OP_BRANCH, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_BRANCH, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      op = ops[$urandom_range(0, 4)];
      applyStimulus(($urandom_range(0, 99) != 0), op,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                    1'($urandom), ($urandom_range(0, 4) == 0));
    end

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core with branch/jump targets resolved in ID.
- Detects operand hazards the forwarding network cannot cover: load results needed by an ID-stage branch/JALR, and classic load-use.
- Generates the stall, flush and redirect controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Freezes the whole pipe while data memory is busy.
- Keeps stall and flush performance counters.

Parameters:
CNT_W, 32, width of performance counters.
BR_LD_EX_STALL, 2, stall cycles when an ID branch/JALR needs a load currently in EX (1..3).

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
i_ifid_opcode  in  7  opcode of instruction in ID
i_ifid_rs1addr  in  5  ID rs1 address
i_ifid_rs2addr  in  5  ID rs2 address
i_idex_rdaddr  in  5  EX-stage destination
i_idex_rdwren  in  1  EX-stage writes rd
i_idex_memrd  in  1  EX-stage instruction is a load
i_exmem_rdaddr  in  5  MEM-stage destination
i_exmem_rdwren  in  1  MEM-stage writes rd
i_exmem_memrd  in  1  MEM-stage instruction is a load
i_br_taken  in  1  ID branch comparator result (conditional branches only)
i_dmem_busy  in  1  data memory not ready
o_pc_en  out  1  PC register enable
o_pc_sel  out  1  1 = load PC with branch target
o_ifid_en  out  1  IF/ID enable
o_ifid_flush  out  1  IF/ID clear to NOP
o_idex_flush  out  1  ID/EX clear to NOP (bubble)
o_exmem_en  out  1  EX/MEM enable
o_memwb_en  out  1  MEM/WB enable
o_stall_cnt  out  CNT_W  cycles with o_pc_en=0
o_flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Decode in ID:
  - is_br: opcode 1100011 (uses rs1, rs2).
  - is_jalr: opcode 1100111 (uses rs1).
  - is_jal: opcode 1101111 (uses no source register).
  - Any other opcode is treated as using rs1 and rs2.
  - A source matches a stage when that stage's rdwren=1, rdaddr!=0 and rdaddr equals the source address.
- Stall need, computed combinationally in RUN:
  - (is_br|is_jalr) with an EX match and idex_memrd: need = BR_LD_EX_STALL.
  - (is_br|is_jalr) with an EX match and a non-load: need = 1 (ALU result is not ready in ID in time).
  - (is_br|is_jalr) with a MEM match and exmem_memrd: need = 1.
  - Other instruction with an EX match and idex_memrd: need = 1.
  - Otherwise need = 0.
- FSM states: RUN, STALL. Register rem (2 bits); reset: state=RUN, rem=0.
- RUN, need>0: stall this cycle (o_pc_en=0, o_ifid_en=0, o_idex_flush=1). rem<=need-1. Next state is STALL if need>1, else RUN.
- STALL: stall outputs as above. rem<=rem-1. Go to RUN when rem==1. No re-detection while in STALL.
- RUN, need==0: all enables 1.
  - Redirect when is_jal | is_jalr | (is_br & i_br_taken): o_pc_sel=1, o_ifid_flush=1 (squash the wrong-path fetch), o_flush_cnt++.
  - Redirect is never asserted in a stall cycle.
- i_dmem_busy=1 has highest priority:
  - All enables 0; o_pc_sel, o_ifid_flush and o_idex_flush are 0.
  - FSM, rem and o_flush_cnt hold.
  - o_stall_cnt increments.
- o_stall_cnt increments in every cycle with o_pc_en=0. Both counters wrap modulo 2^CNT_W.
- All outputs are combinational from state/inputs except the counters, which are registered.
- Reset values (i_rst_n low, asynchronous):
  - o_pc_en, o_ifid_en, o_exmem_en, o_memwb_en = 0.
  - o_pc_sel, o_ifid_flush, o_idex_flush = 0.
  - Counters = 0.
  - Outputs stay at these values while reset is asserted. Reset mid-STALL abandons the stall and returns to RUN.

Decomposition:
- Shared package core_pkg:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD.
  - state_e {RUN, STALL}.
- One natural sub-module: hazard_detect, the combinational match/need logic. The top keeps the FSM, output mux and counters.

Test Plan:
1. Reset asserted mid-STALL (rem=1) -> all enables 0 during reset; after release state=RUN, counters=0.
2. lw x5 in EX (idex_memrd=1, rd=5), ID beq x5,x6 -> 2 cycles of pc_en=0, idex_flush=1, then RUN with pc_en=1; stall_cnt=2.
3. add x7 in EX, ID jalr x0,0(x7) -> 1 stall cycle, then pc_sel=1 and ifid_flush=1 for 1 cycle; flush_cnt=1.
4. ID beq with no hazards, i_br_taken=1 -> same cycle pc_sel=1, ifid_flush=1, idex_flush=0. With i_br_taken=0 -> pc_sel=0.
5. lw x3 in EX, ID add x4,x3,x1 -> exactly 1 bubble (idex_flush=1). Same case with rd=x0 -> no stall.
6. i_dmem_busy=1 for 3 cycles during a 2-cycle branch stall -> all enables 0 for 3 cycles, rem held; the stall completes afterwards; stall_cnt=5.
